// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for a 4-digit display.
// Each digit gets BLANK all-off cycles (anti-ghosting) then DWELL lit cycles;
// one frame is 4*(BLANK+DWELL) cycles. A one-deep pending buffer accepts new
// frames at any time; they become active only at a frame boundary, so the
// displayed frame never changes mid-scan.
//
// Optional feature: define DISP_LZ_BLANK_EN to suppress leading-zero digits
// (digit 0 is always lit). Timing and handshake are unaffected.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   synchronous active-low reset
//   en           in   scan enable
//   frame_in     in   [15:0] four hex digits, [3:0] = digit 0 (rightmost)
//   frame_valid  in   qualifies frame_in
//   frame_ready  out  pending buffer empty, frame can be accepted
//   an           out  [3:0] active-low digit enables
//   hex_out      out  [3:0] nibble of the scanned digit
//   digit_idx    out  [1:0] index of the scanned digit
//   frame_start  out  one-cycle pulse at the start of each frame
module disp_scan_ctrl #(
    parameter int unsigned DWELL = 12500,
    parameter int unsigned BLANK = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [3:0]  an,
    output logic [3:0]  hex_out,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    localparam logic StBlk  = 1'b0;
    localparam logic StShow = 1'b1;

    localparam logic [19:0] BlankLast = 20'(BLANK - 1);
    localparam logic [19:0] DwellLast = 20'(DWELL - 1);

    logic        state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic [19:0] cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [15:0] active_q, active_d;
    logic [15:0] pending_q, pending_d;
    logic        pending_full_q, pending_full_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  hex_q, hex_d;
    logic        frame_start_q, frame_start_d;

    logic        boundary;
    logic        accept;
    logic [3:0]  lz_mask;

    assign accept = frame_valid & ~pending_full_q;

    // Leading-zero mask over the next active frame; bit d set = suppress digit d.
`ifdef DISP_LZ_BLANK_EN
    always_comb begin
        lz_mask    = 4'b0000;
        lz_mask[3] = (active_d[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] & (active_d[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] & (active_d[7:4] == 4'h0);
    end
`else
    assign lz_mask = 4'b0000;
`endif

    always_comb begin
        state_d        = state_q;
        digit_d        = digit_q;
        cnt_d          = cnt_q;
        run_d          = run_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        boundary       = 1'b0;

        if (!en) begin
            state_d = StBlk;
            digit_d = 2'd0;
            cnt_d   = 20'd0;
            run_d   = 1'b0;
        end else if (!run_q) begin
            // First cycle after enable (or reset release) opens a fresh frame.
            run_d    = 1'b1;
            state_d  = StBlk;
            digit_d  = 2'd0;
            cnt_d    = 20'd0;
            boundary = 1'b1;
        end else if (state_q == StBlk) begin
            if (cnt_q == BlankLast) begin
                state_d = StShow;
                cnt_d   = 20'd0;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end else begin
            if (cnt_q == DwellLast) begin
                state_d  = StBlk;
                cnt_d    = 20'd0;
                digit_d  = digit_q + 2'd1;
                boundary = (digit_q == 2'd3);
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end

        // Transfer and accept are mutually exclusive: accept needs pending empty.
        if (boundary && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = frame_in;
            pending_full_d = 1'b1;
        end
    end

    always_comb begin
        frame_start_d = boundary;
        unique case (digit_d)
            2'd0:    hex_d = active_d[3:0];
            2'd1:    hex_d = active_d[7:4];
            2'd2:    hex_d = active_d[11:8];
            default: hex_d = active_d[15:12];
        endcase
        if (state_d == StShow && !lz_mask[digit_d]) begin
            an_d = ~(4'b0001 << digit_d);
        end else begin
            an_d = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StBlk;
            digit_q        <= 2'd0;
            cnt_q          <= 20'd0;
            run_q          <= 1'b0;
            active_q       <= 16'h0000;
            pending_q      <= 16'h0000;
            pending_full_q <= 1'b0;
            an_q           <= 4'b1111;
            hex_q          <= 4'h0;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            digit_q        <= digit_d;
            cnt_q          <= cnt_d;
            run_q          <= run_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            an_q           <= an_d;
            hex_q          <= hex_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign frame_ready = ~pending_full_q;
    assign an          = an_q;
    assign hex_out     = hex_q;
    assign digit_idx   = digit_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed self-checking bench for disp_scan_ctrl with DWELL=4, BLANK=2.
// Cycle N = values observed just after the N-th rising edge following reset
// release (edge 0 = first edge with reset_n high and en high). Inputs driven
// "at cycle N" are sampled by edge N+1.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [15:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  an;
    logic [3:0]  hex_out;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    disp_scan_ctrl #(
        .DWELL(4),
        .BLANK(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .an         (an),
        .hex_out    (hex_out),
        .digit_idx  (digit_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Reset for a few edges, then release with en=1; returns positioned at cycle 0.
    task automatic start();
        reset_n     = 1'b0;
        en          = 1'b0;
        frame_valid = 1'b0;
        frame_in    = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        en      = 1'b1;
        @(posedge clk);
        cyc = 0;
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        en          = 1'b1;
        frame_valid = 1'b1;
        frame_in    = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1111 || hex_out !== 4'h0 || frame_start !== 1'b0 ||
            frame_ready !== 1'b1 || digit_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: an=%b hex=%h fs=%b rdy=%b idx=%0d want 1111 0 0 1 0",
                     an, hex_out, frame_start, frame_ready, digit_idx);
        end
        frame_valid = 1'b0;
    endtask

    task automatic test_scan();
        int pos, d, off;
        logic [3:0] exp_an;
        start();
        while (cyc < 48) begin
            pos    = cyc % 24;
            d      = pos / 6;
            off    = pos % 6;
            exp_an = (off < 2) ? 4'b1111 : ~(4'b0001 << d);
            checks++;
            if (an !== exp_an || frame_start !== (pos == 0) || digit_idx !== 2'(d)) begin
                failures++;
                $display("FAIL scan c%0d: an=%b fs=%b idx=%0d want an=%b fs=%b idx=%0d",
                         cyc, an, frame_start, digit_idx, exp_an, (pos == 0), d);
            end
            step();
        end
    endtask

    task automatic test_frame_load();
        start();
        while (cyc <= 32) begin
            if (cyc <= 23) begin
                checks++;
                if (hex_out !== 4'h0) begin
                    failures++;
                    $display("FAIL load_early c%0d: hex=%h want 0", cyc, hex_out);
                end
            end
            if (cyc == 4) begin
                checks++;
                if (frame_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL load_ready c4: rdy=%b want 0", frame_ready);
                end
            end
            if (cyc == 24 || cyc == 26) begin
                checks++;
                if (hex_out !== 4'h4 || (cyc == 26 && an !== 4'b1110)) begin
                    failures++;
                    $display("FAIL load_d0 c%0d: hex=%h an=%b want 4 (an 1110 at c26)",
                             cyc, hex_out, an);
                end
            end
            if (cyc == 32) begin
                checks++;
                if (hex_out !== 4'h3 || an !== 4'b1101) begin
                    failures++;
                    $display("FAIL load_d1 c32: hex=%h an=%b want 3 1101", hex_out, an);
                end
            end
            frame_valid = (cyc == 3);
            frame_in    = (cyc == 3) ? 16'h1234 : 16'h0000;
            step();
        end
        frame_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        start();
        while (cyc <= 48) begin
            if (cyc >= 2 && cyc <= 23) begin
                checks++;
                if (frame_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_ready c%0d: rdy=%b want 0", cyc, frame_ready);
                end
            end
            if (cyc == 24 || cyc == 26) begin
                checks++;
                if (hex_out !== 4'hA) begin
                    failures++;
                    $display("FAIL bp_first c%0d: hex=%h want a", cyc, hex_out);
                end
            end
            if (cyc == 25) begin
                checks++;
                if (frame_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_second_acc c25: rdy=%b want 0", frame_ready);
                end
            end
            if (cyc == 48) begin
                checks++;
                if (hex_out !== 4'h5 || frame_start !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_second c48: hex=%h fs=%b want 5 1", hex_out, frame_start);
                end
            end
            if (cyc == 1) begin
                frame_valid = 1'b1;
                frame_in    = 16'hAAAA;
            end else if (cyc >= 2 && cyc <= 24) begin
                frame_valid = 1'b1;
                frame_in    = 16'h5555;
            end else begin
                frame_valid = 1'b0;
            end
            step();
        end
        frame_valid = 1'b0;
    endtask

    task automatic test_en_drop();
        start();
        while (cyc <= 18) begin
            if (cyc >= 11 && cyc <= 15) begin
                checks++;
                if (an !== 4'b1111 || digit_idx !== 2'd0 || frame_start !== 1'b0) begin
                    failures++;
                    $display("FAIL en_low c%0d: an=%b idx=%0d fs=%b want 1111 0 0",
                             cyc, an, digit_idx, frame_start);
                end
            end
            if (cyc == 16) begin
                checks++;
                if (frame_start !== 1'b1 || digit_idx !== 2'd0 || an !== 4'b1111 ||
                    hex_out !== 4'h9) begin
                    failures++;
                    $display("FAIL en_rise c16: fs=%b idx=%0d an=%b hex=%h want 1 0 1111 9",
                             frame_start, digit_idx, an, hex_out);
                end
            end
            if (cyc == 17) begin
                checks++;
                if (frame_start !== 1'b0 || an !== 4'b1111) begin
                    failures++;
                    $display("FAIL en_blank c17: fs=%b an=%b want 0 1111", frame_start, an);
                end
            end
            if (cyc == 18) begin
                checks++;
                if (an !== 4'b1110) begin
                    failures++;
                    $display("FAIL en_show c18: an=%b want 1110", an);
                end
            end
            en          = !(cyc >= 10 && cyc < 15);
            frame_valid = (cyc == 12);
            frame_in    = 16'h00B9;
            step();
        end
        frame_valid = 1'b0;
        en          = 1'b1;
    endtask

    task automatic test_mid_reset();
        start();
        // Active 0x1234 from c24, pending 0x5678 from c26; reset at c37.
        while (cyc <= 37) begin
            frame_valid = (cyc == 0) || (cyc == 25);
            frame_in    = (cyc == 0) ? 16'h1234 : 16'h5678;
            reset_n     = (cyc != 37);
            if (cyc == 32) begin
                checks++;
                if (hex_out !== 4'h3) begin
                    failures++;
                    $display("FAIL mid_pre c32: hex=%h want 3", hex_out);
                end
            end
            step();
        end
        frame_valid = 1'b0;
        checks++;
        if (an !== 4'b1111 || frame_ready !== 1'b1 || hex_out !== 4'h0 ||
            frame_start !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset c38: an=%b rdy=%b hex=%h fs=%b want 1111 1 0 0",
                     an, frame_ready, hex_out, frame_start);
        end
        reset_n = 1'b1;
        step();
        cyc = 0;
        while (cyc <= 32) begin
            if (cyc == 0 || cyc == 8 || cyc == 24 || cyc == 32) begin
                checks++;
                if (hex_out !== 4'h0) begin
                    failures++;
                    $display("FAIL mid_after c%0d: hex=%h want 0", cyc, hex_out);
                end
            end
            step();
        end
    endtask

    task automatic test_lz();
        start();
        while (cyc <= 44) begin
            frame_valid = (cyc == 0);
            frame_in    = 16'h0070;
            if (cyc == 26) begin
                checks++;
                if (an !== 4'b1110 || hex_out !== 4'h0) begin
                    failures++;
                    $display("FAIL lz_d0 c26: an=%b hex=%h want 1110 0", an, hex_out);
                end
            end
            if (cyc == 32) begin
                checks++;
                if (an !== 4'b1101 || hex_out !== 4'h7) begin
                    failures++;
                    $display("FAIL lz_d1 c32: an=%b hex=%h want 1101 7", an, hex_out);
                end
            end
`ifdef DISP_LZ_BLANK_EN
            if (cyc == 38 || cyc == 44) begin
                checks++;
                if (an !== 4'b1111 || digit_idx !== ((cyc == 38) ? 2'd2 : 2'd3)) begin
                    failures++;
                    $display("FAIL lz_hi c%0d: an=%b idx=%0d want 1111", cyc, an, digit_idx);
                end
            end
`else
            if (cyc == 38 || cyc == 44) begin
                checks++;
                if (an !== ((cyc == 38) ? 4'b1011 : 4'b0111) || hex_out !== 4'h0) begin
                    failures++;
                    $display("FAIL lz_off c%0d: an=%b hex=%h", cyc, an, hex_out);
                end
            end
`endif
            step();
        end
        frame_valid = 1'b0;
        // Frame 0x0000 straight out of reset: digit 0 always lit.
        start();
        while (cyc <= 8) begin
            if (cyc == 2) begin
                checks++;
                if (an !== 4'b1110) begin
                    failures++;
                    $display("FAIL lz_zero_d0 c2: an=%b want 1110", an);
                end
            end
            if (cyc == 8) begin
                checks++;
`ifdef DISP_LZ_BLANK_EN
                if (an !== 4'b1111) begin
                    failures++;
                    $display("FAIL lz_zero_d1 c8: an=%b want 1111", an);
                end
`else
                if (an !== 4'b1101) begin
                    failures++;
                    $display("FAIL lz_zero_d1 c8: an=%b want 1101", an);
                end
`endif
            end
            step();
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        en          = 1'b0;
        frame_valid = 1'b0;
        frame_in    = 16'h0000;
        test_reset();
        test_scan();
        test_frame_load();
        test_back_to_back();
        test_en_drop();
        test_mid_reset();
        test_lz();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
